reg_bank_16bit_6r: RTL and testbench

- Bank of six 16-bit registers feeding the six data inputs (a..f) of the downstream 16-bit 6-input mux.
- Also owns the mux select register s, loaded through a valid/ready read-request handshake.
- Sits between the register write-back path and the operand mux in the multi-register accumulator datapath.
- One write port, one select/read-request port, address-error reporting.

---
 rtl/reg_bank_16bit_6r_pkg.sv | 24 ++
 rtl/reg_bank_16bit_6r_sel_handshake_reg.sv | 61 ++++++
 rtl/reg_bank_16bit_6r.sv | 91 +++++++++
 tb/tb_reg_bank_16bit_6r.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_16bit_6r_pkg.sv
// Shared constants, register indices and select type for the six-register operand bank.
package reg_bank_16bit_6r_pkg;

    localparam int WIDTH = 16;
    localparam int NREGS = 6;
    localparam int SEL_W = 3;

    localparam int R_A = 0;
    localparam int R_B = 1;
    localparam int R_C = 2;
    localparam int R_D = 3;
    localparam int R_E = 4;
    localparam int R_F = 5;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic sel_legal(input sel_t idx);
        return int'(idx) < NREGS;
    endfunction

endpackage

// File: rtl/reg_bank_16bit_6r_sel_handshake_reg.sv
// Select register s with valid/ready load handshake and illegal-select detection.
// Handshake: a request transfers on an edge where rd_req & rd_ack; a held selection is
// consumed on an edge where rd_valid & rd_ready; s never changes while rd_valid & !rd_ready.
module reg_bank_16bit_6r_sel_handshake_reg
    import reg_bank_16bit_6r_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_req,
    input  sel_t rd_sel,
    input  logic rd_ready,
    output logic rd_ack,
    output logic rd_valid,
    output sel_t s,
    output logic rd_ill
);

    typedef enum logic {HS_EMPTY = 1'b0, HS_FULL = 1'b1} hs_state_t;

    hs_state_t state_q, state_next;
    sel_t      s_q, s_next;
    logic      ill_hold_q, ill_hold_next;
    sel_t      ill_sel_q;
    logic      sel_ok, can_accept, ill_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HS_EMPTY;
            s_q        <= '0;
            ill_hold_q <= 1'b0;
            ill_sel_q  <= '0;
        end else begin
            state_q    <= state_next;
            s_q        <= s_next;
            ill_hold_q <= ill_hold_next;
            ill_sel_q  <= rd_sel;
        end
    end

    always_comb begin
        state_next    = state_q;
        s_next        = s_q;
        sel_ok        = sel_legal(rd_sel);
        can_accept    = (state_q == HS_EMPTY) || rd_ready;
        rd_ack        = !rst && rd_req && sel_ok && can_accept;
        // An illegal request held unchanged is reported only once.
        ill_repeat    = ill_hold_q && (rd_sel == ill_sel_q);
        rd_ill        = !rst && rd_req && !sel_ok && can_accept && !ill_repeat;
        ill_hold_next = rd_req && !sel_ok && (rd_ill || ill_repeat);
        if (rd_ack) begin
            state_next = HS_FULL;
            s_next     = rd_sel;
        end else if (state_q == HS_FULL && rd_ready) begin
            state_next = HS_EMPTY;
        end
    end

    assign rd_valid = (state_q == HS_FULL);
    assign s        = s_q;

endmodule

// File: rtl/reg_bank_16bit_6r.sv
// Six 16-bit operand registers, write decode, select handshake and error accounting.
// Optional macro WR_BYPASS_EN forwards wr_data combinationally onto the addressed output.
module reg_bank_16bit_6r
    import reg_bank_16bit_6r_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_req,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic                 rd_ack,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [SEL_W-1:0]     s,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     e,
    output logic [WIDTH-1:0]     f,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0]     regs_q   [NREGS];
    logic [WIDTH-1:0]     data_out [NREGS];
    logic                 rd_ill, wr_ill, err_evt;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    reg_bank_16bit_6r_sel_handshake_reg u_sel (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_ready (rd_ready),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .s        (s),
        .rd_ill   (rd_ill)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (wr_en && int'(wr_addr) == i) begin
                regs_q[i] <= wr_data;
            end
        end
    end

    // Illegal write and illegal read in the same cycle are one event.
    assign wr_ill  = wr_en && !sel_legal(wr_addr);
    assign err_evt = wr_ill || rd_ill;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= err_evt;
            if (err_evt && err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            data_out[i] = regs_q[i];
`ifdef WR_BYPASS_EN
            if (wr_en && int'(wr_addr) == i) begin
                data_out[i] = wr_data;
            end
`endif
        end
    end

    assign a       = data_out[R_A];
    assign b       = data_out[R_B];
    assign c       = data_out[R_C];
    assign d       = data_out[R_D];
    assign e       = data_out[R_E];
    assign f       = data_out[R_F];
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_reg_bank_16bit_6r.sv
// Self-checking bench for reg_bank_16bit_6r: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the register bank.
module tb_reg_bank_16bit_6r;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_ack;
    logic        rd_ready;
    logic        rd_valid;
    logic [2:0]  s;
    logic [15:0] a, b, c, d, e, f;
    logic        err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    reg_bank_16bit_6r dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_ack   (rd_ack),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .s        (s),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    logic [15:0] dout [6];
    always_comb begin
        dout[0] = a; dout[1] = b; dout[2] = c;
        dout[3] = d; dout[4] = e; dout[5] = f;
    end

    // Behavioural model
    logic [15:0] m_regs [6];
    int          m_s;
    bit          m_valid;
    bit          m_err;
    int          m_cnt;
    bit          m_held;
    int          m_held_sel;
    bit          m_known = 0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int exp_out(input int i);
        int v;
        v = m_regs[i];
`ifdef WR_BYPASS_EN
        if (wr_en && int'(wr_addr) == i) v = wr_data;
`endif
        return v;
    endfunction

    function automatic bit model_ack();
        return !rst && rd_req && rd_sel < 6 && (!m_valid || rd_ready);
    endfunction

    task automatic compare_now();
        chk("rd_ack", int'(rd_ack), int'(model_ack()));
        if (!m_known) return;
        for (int i = 0; i < 6; i++) chk($sformatf("reg%0d", i), int'(dout[i]), exp_out(i));
        chk("s", int'(s), m_s);
        chk("rd_valid", int'(rd_valid), int'(m_valid));
        chk("err", int'(err), int'(m_err));
        chk("err_cnt", int'(err_cnt), m_cnt);
        if (m_valid) chk("mux_out", int'(dout[s]), exp_out(m_s));
    endtask

    task automatic model_update();
        bit ack, cand, counted, wr_bad;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_s = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_held = 0; m_held_sel = 0;
            m_known = 1;
            return;
        end
        ack     = model_ack();
        wr_bad  = wr_en && wr_addr >= 6;
        cand    = rd_req && rd_sel >= 6 && (!m_valid || rd_ready);
        counted = cand && !(m_held && m_held_sel == int'(rd_sel));
        m_held  = rd_req && rd_sel >= 6 && (counted || (m_held && m_held_sel == int'(rd_sel)));
        m_held_sel = rd_sel;
        if (wr_en && wr_addr < 6) m_regs[wr_addr] = wr_data;
        m_err = wr_bad || counted;
        if (m_err && m_cnt < 255) m_cnt++;
        if (ack) begin
            m_s = rd_sel;
            m_valid = 1;
        end else if (m_valid && rd_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       input bit rq, input logic [2:0] rs, input bit ry);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_req = rq; rd_sel = rs; rd_ready = ry;
        @(negedge clk);
        compare_now();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input bit ry);
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0, ry);
    endtask

    initial begin
        // 1. reset
        cyc(1, 0, 3'd0, 16'h0, 0, 3'd0, 0);
        cyc(1, 0, 3'd0, 16'h0, 0, 3'd0, 0);
        idle(0);
        chk("reset_a", int'(a), 0);
        chk("reset_s", int'(s), 0);
        chk("reset_valid", int'(rd_valid), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);

        // 2. fill registers, then step the select through all of them
        for (int i = 0; i < 6; i++) cyc(0, 1, 3'(i), 16'(8 << i), 0, 3'd0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 3'd0, 16'h0, 1, 3'(i), 1);
        chk("step_s", int'(s), 5);
        chk("step_valid", int'(rd_valid), 1);

        // 3. back-pressure
        for (int i = 0; i < 4; i++) cyc(0, 0, 3'd0, 16'h0, 1, 3'd3, 0);
        chk("bp_s_frozen", int'(s), 5);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd3, 1);
        chk("bp_s_loaded", int'(s), 3);
        idle(1);
        idle(0);
        chk("lit_a", int'(a), 8);
        chk("lit_b", int'(b), 16);
        chk("lit_c", int'(c), 32);
        chk("lit_d", int'(d), 64);
        chk("lit_e", int'(e), 128);
        chk("lit_f", int'(f), 256);

        // 4. illegal write and illegal select
        cyc(0, 1, 3'd7, 16'hFFFF, 0, 3'd0, 0);
        chk("ill_wr_err", int'(err), 1);
        chk("ill_wr_cnt", int'(err_cnt), 1);
        idle(0);
        chk("err_pulse_end", int'(err), 0);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd6, 0);
        idle(0);
        chk("ill_cnt_2", int'(err_cnt), 2);
        chk("ill_f_kept", int'(f), 256);
        for (int i = 0; i < 3; i++) cyc(0, 0, 3'd0, 16'h0, 1, 3'd7, 0);
        idle(0);
        chk("ill_held_once", int'(err_cnt), 3);

        // 5. write and acked select of the same register
        cyc(0, 1, 3'd2, 16'h1234, 1, 3'd2, 1);
        chk("wr_rd_c", int'(c), 16'h1234);
        chk("wr_rd_s", int'(s), 2);

        // 6. reset mid-handshake with a pending write
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd4, 1);
        cyc(1, 1, 3'd1, 16'hBEEF, 1, 3'd1, 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_s", int'(s), 0);
        idle(0);
        chk("rst_b", int'(b), 0);
        chk("rst_cnt", int'(err_cnt), 0);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) cyc(0, 1, 3'($urandom_range(6, 7)), 16'($urandom), 0, 3'd0, 0);
        idle(0);
        chk("sat_cnt", int'(err_cnt), 255);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                16'($urandom), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
